ethernet_decapsulation: RTL and testbench

//  Receive-side counterpart of the ethernet_encapsulation transmitter. Consumes GMII receive bytes and

---
 rtl/ethernet_decapsulation.sv | 234 +++++++++++++++++++++++
 tb/tb_ethernet_decapsulation.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_decapsulation.sv
// ethernet_decapsulation
//   Receive-side Ethernet framer. Consumes GMII receive bytes, strips the
//   preamble/SFD, filters on destination MAC, captures the source MAC and
//   length field, and streams payload bytes to the RX buffer with one cycle
//   of latency. Pad bytes are dropped. The frame is checked against its FCS
//   (CRC-32). Every frame that leaves IDLE ends in exactly one status pulse.
//
// Ports
//   clk          single clock; GMII RX is already in this domain
//   rst          asynchronous, active-low reset
//   gmii_rxd     received byte
//   gmii_rx_dv   receive data valid
//   gmii_rx_er   receive error
//   data_out     payload byte to RX buffer
//   data_valid   data_out carries a payload byte (no backpressure)
//   data_last    with data_valid: final payload byte of the frame
//   src_mac      source MAC of the current/last frame
//   len_field    length field of the current/last frame
//   frame_ok     1-cycle pulse: frame accepted, FCS good
//   frame_err    1-cycle pulse: frame rejected, downstream discards its bytes
//   err_code     cause of the last frame_err; held until the next pulse
module ethernet_decapsulation #(
  parameter logic [47:0] LOCAL_MAC   = 48'h023528fbdd66,
  parameter bit          PROMISC     = 1'b0,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          MIN_PAYLOAD = 46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic [47:0] src_mac,
  output logic [15:0] len_field,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS, CHECK, DROP
  } state_t;

  localparam logic [2:0]  ERR_PREAMBLE = 3'd1;
  localparam logic [2:0]  ERR_ADDR     = 3'd2;
  localparam logic [2:0]  ERR_LEN      = 3'd3;
  localparam logic [2:0]  ERR_TRUNC    = 3'd4;
  localparam logic [2:0]  ERR_CRC      = 3'd5;
  localparam logic [2:0]  ERR_RXER     = 3'd6;
  localparam logic [2:0]  ERR_LONG     = 3'd7;
  localparam logic [15:0] MAX_LEN      = 16'(MAX_PAYLOAD);
  localparam logic [15:0] MIN_LEN      = 16'(MIN_PAYLOAD);
  localparam logic [10:0] MIN_CNT      = 11'(MIN_PAYLOAD);
  localparam logic [10:0] PREAMBLE_MAX = 11'd7;
  // Good-frame residue expressed in normal (non-reflected) bit order.
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

  // Reflected IEEE 802.3 CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  state_t      state, state_d;
  logic [10:0] cnt, cnt_d, cnt_inc, pad_len;
  logic [31:0] crc, crc_d, crc_upd, residue;
  logic [39:0] dest, dest_d;
  logic [47:0] dest_shift, src_d;
  logic [15:0] len_d, len_shift;
  logic [7:0]  data_d;
  logic        valid_d, last_d, ok_d, err_d, addr_ok;
  logic [2:0]  code_d;

  assign crc_upd    = crc32_byte(crc, gmii_rxd);
  // The shift register holds the reflected CRC; reverse it to compare against the normal-order residue.
  assign residue    = {<<{crc}};
  assign cnt_inc    = cnt + 11'd1;
  assign dest_shift = {dest, gmii_rxd};
  assign len_shift  = {len_field[7:0], gmii_rxd};
  assign pad_len    = MIN_CNT - len_field[10:0];
  assign addr_ok    = PROMISC || (dest_shift == LOCAL_MAC) || (dest_shift == 48'hFFFF_FFFF_FFFF);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d = state;
    cnt_d   = cnt;
    crc_d   = crc;
    dest_d  = dest;
    src_d   = src_mac;
    len_d   = len_field;
    data_d  = data_out;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code;

    // A receive error outranks every other check once a frame has started.
    if (gmii_rx_dv && gmii_rx_er && state != IDLE && state != DROP) begin
      state_d = DROP; err_d = 1'b1; code_d = ERR_RXER;
    end else begin
      unique case (state)
        IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rxd == 8'h55) begin
              state_d = PREAMBLE; cnt_d = 11'd1;
            end else begin
              state_d = DROP; err_d = 1'b1; code_d = ERR_PREAMBLE;
            end
          end
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_d = IDLE; err_d = 1'b1; code_d = ERR_PREAMBLE;
          end else if (gmii_rxd == 8'hD5) begin
            state_d = DEST_MAC; cnt_d = '0; crc_d = '1;
          end else if (gmii_rxd == 8'h55 && cnt < PREAMBLE_MAX) begin
            cnt_d = cnt_inc;
          end else begin
            state_d = DROP; err_d = 1'b1; code_d = ERR_PREAMBLE;
          end
        end
        DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS: begin
          if (!gmii_rx_dv) begin
            state_d = IDLE; err_d = 1'b1; code_d = ERR_TRUNC;
          end else begin
            crc_d = crc_upd;
            cnt_d = cnt_inc;
            case (state)
              DEST_MAC: begin
                dest_d = dest_shift[39:0];
                if (cnt == 11'd5) begin
                  cnt_d = '0;
                  if (addr_ok) state_d = SRC_MAC;
                  else begin
                    state_d = DROP; err_d = 1'b1; code_d = ERR_ADDR;
                  end
                end
              end
              SRC_MAC: begin
                src_d = {src_mac[39:0], gmii_rxd};
                if (cnt == 11'd5) begin
                  cnt_d = '0; state_d = LEN;
                end
              end
              LEN: begin
                len_d = len_shift;
                if (cnt == 11'd1) begin
                  cnt_d = '0;
                  if (len_shift == 16'd0 || len_shift > MAX_LEN) begin
                    state_d = DROP; err_d = 1'b1; code_d = ERR_LEN;
                  end else state_d = PAYLOAD;
                end
              end
              PAYLOAD: begin
                data_d  = gmii_rxd;
                valid_d = 1'b1;
                if (cnt_inc == len_field[10:0]) begin
                  last_d = 1'b1; cnt_d = '0;
                  if (len_field < MIN_LEN) state_d = PAD;
                  else state_d = FCS;
                end
              end
              PAD: begin
                if (cnt_inc == pad_len) begin
                  cnt_d = '0; state_d = FCS;
                end
              end
              FCS: begin
                if (cnt == 11'd3) begin
                  cnt_d = '0; state_d = CHECK;
                end
              end
              default: ;
            endcase
          end
        end
        CHECK: begin
          if (gmii_rx_dv) begin
            state_d = DROP; err_d = 1'b1; code_d = ERR_LONG;
          end else begin
            state_d = IDLE;
            if (residue == CRC_RESIDUE) ok_d = 1'b1;
            else begin
              err_d = 1'b1; code_d = ERR_CRC;
            end
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      crc        <= '1;
      dest       <= '0;
      src_mac    <= '0;
      len_field  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      crc        <= crc_d;
      dest       <= dest_d;
      src_mac    <= src_d;
      len_field  <= len_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      data_last  <= last_d;
      frame_ok   <= ok_d;
      frame_err  <= err_d;
      err_code   <= code_d;
    end
  end

endmodule

// File: tb/tb_ethernet_decapsulation.sv
// tb_ethernet_decapsulation
//   Table-driven bench for ethernet_decapsulation. Each record describes a
//   frame (preamble length, DA, length, faults to inject) and its expected
//   outcome; the bench builds the wire bytes with its own FCS generator,
//   drives them, and a negedge monitor tallies what the DUT streams out.
//   Reset behaviour is covered by hand-written sequences.
module tb_ethernet_decapsulation;

  localparam logic [47:0] LOCAL_MAC = 48'h023528fbdd66;
  localparam logic [47:0] SRC_ADDR  = 48'h072227acdb65;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER     = 48'h112233445566;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_last;
  logic [47:0] src_mac;
  logic [15:0] len_field;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;

  ethernet_decapsulation dut (
    .clk        (clk),
    .rst        (rst),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_last  (data_last),
    .src_mac    (src_mac),
    .len_field  (len_field),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pre_len;   // number of 8'h55 bytes before the SFD
    logic [47:0] da;
    logic [15:0] len;
    int          trunc;     // payload bytes sent before dv drops (-1: whole frame)
    int          rxer_at;   // wire byte index carrying rx_er (-1: none)
    int          flip_at;   // payload byte with a flipped bit after FCS (-1: none)
    int          extra;     // bytes appended after the FCS
    int          exp_valid;
    bit          exp_last;
    bit          exp_ok;
    logic [2:0]  exp_code;
    bit          chk_hdr;   // src_mac/len_field must hold this frame's values
  } vec_t;

  vec_t  vecs[$];
  string names[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  wire_q[$];
  logic [7:0]  exp_pay[$];
  logic [31:0] tx_crc;
  int          hdr_at;
  int          send_n;

  // Monitor state.
  int cyc = 0;
  int vcount, lcount, okcount, errcount, bad, status_cyc, fall_cyc, cur_len;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      if (vcount < exp_pay.size()) begin
        if (data_out !== exp_pay[vcount]) bad++;
      end
      if (data_last) begin
        lcount++;
        if (vcount + 1 != cur_len) bad++;
      end
      vcount++;
    end else if (data_last) bad++;
    if (frame_ok)  begin okcount++;  status_cyc = cyc; end
    if (frame_err) begin errcount++; status_cyc = cyc; end
    if (frame_ok && frame_err) bad++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input int pre, input logic [47:0] da, input logic [15:0] len,
                     input int trunc, input int rxer, input int flip, input int extra,
                     input int ev, input bit el, input bit eok, input logic [2:0] ec, input bit hdr);
    vec_t v;
    v.pre_len = pre;  v.da = da;        v.len = len;
    v.trunc = trunc;  v.rxer_at = rxer; v.flip_at = flip; v.extra = extra;
    v.exp_valid = ev; v.exp_last = el;  v.exp_ok = eok;   v.exp_code = ec; v.chk_hdr = hdr;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  // Transmitter-side CRC: one bit at a time, feedback from register LSB xor data bit.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < 8; j++) begin
      if (r[0] ^ b[j]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_crc(input logic [7:0] b);
    wire_q.push_back(b);
    tx_crc = crc_step(tx_crc, b);
  endtask

  task automatic build(input vec_t v, input int seed);
    int          npay, npad;
    logic [31:0] fcs;
    logic [47:0] sa;
    logic [7:0]  b;
    sa = SRC_ADDR;
    wire_q.delete();
    exp_pay.delete();
    for (int i = 0; i < v.pre_len; i++) wire_q.push_back(8'h55);
    wire_q.push_back(8'hD5);
    tx_crc = 32'hFFFF_FFFF;
    for (int i = 5; i >= 0; i--) push_crc(v.da[8*i +: 8]);
    for (int i = 5; i >= 0; i--) push_crc(sa[8*i +: 8]);
    push_crc(v.len[15:8]);
    push_crc(v.len[7:0]);
    hdr_at = wire_q.size();
    npay = (v.len > 16'd1500) ? 8 : int'(v.len);
    for (int k = 0; k < npay; k++) begin
      b = 8'(k * 37 + seed * 5 + 11);
      push_crc(b);
      exp_pay.push_back(b);
    end
    npad = (npay < 46) ? 46 - npay : 0;
    for (int k = 0; k < npad; k++) push_crc(8'h00);
    fcs = ~tx_crc;
    for (int i = 0; i < 4; i++) wire_q.push_back(fcs[8*i +: 8]);
    for (int i = 0; i < v.extra; i++) wire_q.push_back(8'hAA);
    if (v.flip_at >= 0) begin
      wire_q[hdr_at + v.flip_at] = wire_q[hdr_at + v.flip_at] ^ 8'h08;
      exp_pay[v.flip_at]         = exp_pay[v.flip_at] ^ 8'h08;
    end
    send_n = (v.trunc >= 0) ? hdr_at + v.trunc : wire_q.size();
  endtask

  task automatic clear_mon(input int len);
    vcount = 0; lcount = 0; okcount = 0; errcount = 0; bad = 0;
    status_cyc = -1; cur_len = len;
  endtask

  task automatic drive(input int n, input int rxer_at, input bit drop_dv);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = wire_q[i];
      gmii_rx_er = (i == rxer_at);
    end
    if (drop_dv) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0;
      fall_cyc = cyc;
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t  v;
    string n;
    v = vecs[vi];
    n = names[vi];
    build(v, vi);
    clear_mon(int'(v.len));
    drive(send_n, v.rxer_at, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({n, "/valid"}, 64'(vcount), 64'(v.exp_valid));
    check({n, "/last"},  64'(lcount), 64'(v.exp_last));
    check({n, "/ok"},    64'(okcount), 64'(v.exp_ok));
    check({n, "/err"},   64'(errcount), 64'(!v.exp_ok));
    check({n, "/data"},  64'(bad), 64'd0);
    if (!v.exp_ok) check({n, "/code"}, 64'(err_code), 64'(v.exp_code));
    if (v.exp_ok || v.exp_code == 3'd4 || v.exp_code == 3'd5)
      check({n, "/latency"}, 64'(status_cyc), 64'(fall_cyc + 1));
    if (v.chk_hdr) begin
      check({n, "/src_mac"},   64'(src_mac), 64'(SRC_ADDR));
      check({n, "/len_field"}, 64'(len_field), 64'(v.len));
    end
  endtask

  initial begin
    //   name        pre DA         len       trunc rxer flip xtra  valid last ok code hdr
    add("good",      7, LOCAL_MAC, 16'h0040, -1,  -1,  -1,  0,    64,  1,  1, 3'd0, 1);
    add("short",     7, LOCAL_MAC, 16'h0005, -1,  -1,  -1,  0,     5,  1,  1, 3'd0, 1);
    add("crc_bad",   7, LOCAL_MAC, 16'h0040, -1,  -1,  20,  0,    64,  1,  0, 3'd5, 1);
    add("da_miss",   7, OTHER,     16'h0040, -1,  -1,  -1,  0,     0,  0,  0, 3'd2, 0);
    add("bcast",     7, BCAST,     16'h0040, -1,  -1,  -1,  0,    64,  1,  1, 3'd0, 1);
    add("trunc",     7, LOCAL_MAC, 16'h0040, 10,  -1,  -1,  0,    10,  0,  0, 3'd4, 1);
    add("rx_er_sa",  7, LOCAL_MAC, 16'h0040, -1,  16,  -1,  0,     0,  0,  0, 3'd6, 0);
    add("len_big",   7, LOCAL_MAC, 16'h05DD, -1,  -1,  -1,  0,     0,  0,  0, 3'd3, 1);
    add("len_zero",  7, LOCAL_MAC, 16'h0000, -1,  -1,  -1,  0,     0,  0,  0, 3'd3, 1);
    add("too_long",  7, LOCAL_MAC, 16'h0040, -1,  -1,  -1,  2,    64,  1,  0, 3'd7, 1);
    add("pre8",      8, LOCAL_MAC, 16'h0040, -1,  -1,  -1,  0,     0,  0,  0, 3'd1, 0);
    add("no_pre",    0, LOCAL_MAC, 16'h0040, -1,  -1,  -1,  0,     0,  0,  0, 3'd1, 0);
    add("len_min",   7, LOCAL_MAC, 16'd46,   -1,  -1,  -1,  0,    46,  1,  1, 3'd0, 1);
    add("len_max",   7, LOCAL_MAC, 16'd1500, -1,  -1,  -1,  0,  1500,  1,  1, 3'd0, 1);

    rst = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    clear_mon(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/src_mac", 64'(src_mac), 64'd0);
    check("reset/outputs",
          64'({data_out, data_valid, data_last, len_field, frame_ok, frame_err, err_code}), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int vi = 0; vi < vecs.size(); vi++) run_vec(vi);

    // Reset in the middle of the payload: outputs clear at once, no status pulse.
    build(vecs[0], 0);
    clear_mon(64);
    drive(hdr_at + 20, -1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midrst/src_mac", 64'(src_mac), 64'd0);
    check("midrst/outputs",
          64'({data_out, data_valid, data_last, len_field, frame_ok, frame_err, err_code}), 64'd0);
    gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst/no_pulse", 64'(okcount + errcount), 64'd0);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
